csi2_packet_sequencer: RTL and testbench

//  Sequences one d_phy_receiver lane at packet level. Consumes its byte stream (data/enable),

---
 rtl/csi2_packet_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_csi2_packet_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_packet_sequencer.sv
// Packet-level sequencer for one D-PHY receiver lane: frames CSI-2 packets from the byte stream,
// forwards header and payload, then pulses the receiver reset so it re-hunts the next SoT.
//
// state   | meaning
// IDLE    | waiting for the first byte of a packet (data_id)
// HEADER  | collecting word count LSB, MSB, then the ECC byte
// PAYLOAD | forwarding word_count bytes, one clock after they arrive
// FOOTER  | discarding the two CRC bytes
// FLUSH   | holding rx_reset for RESET_CYCLES clocks; input ignored

module csi2_packet_sequencer #(
  parameter logic [15:0] MAX_WC       = 16'd4096,
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned RESET_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_enable,
  output logic        rx_reset,
  output logic        header_valid,
  output logic [7:0]  data_id,
  output logic [15:0] word_count,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic        packet_done,
  output logic        error,
  output logic [1:0]  error_code,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_FOOTER,
    S_FLUSH
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] RESET_LAST   = 16'(RESET_CYCLES - 1);
  localparam logic [1:0]  ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0]  ERR_WC       = 2'd2;

  state_t      state_q;
  logic [1:0]  hdr_cnt_q;
  logic        crc_cnt_q;
  logic [15:0] remain_q;
  logic [15:0] idle_cnt_q;
  logic [15:0] flush_cnt_q;
  logic        rx_reset_q;
  logic        header_valid_q;
  logic [7:0]  data_id_q;
  logic [15:0] word_count_q;
  logic [7:0]  payload_data_q;
  logic        payload_valid_q;
  logic        packet_done_q;
  logic        error_q;
  logic [1:0]  error_code_q;
  logic        busy_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      hdr_cnt_q       <= 2'd0;
      crc_cnt_q       <= 1'b0;
      remain_q        <= 16'd0;
      idle_cnt_q      <= 16'd0;
      flush_cnt_q     <= 16'd0;
      rx_reset_q      <= 1'b0;
      header_valid_q  <= 1'b0;
      data_id_q       <= 8'd0;
      word_count_q    <= 16'd0;
      payload_data_q  <= 8'd0;
      payload_valid_q <= 1'b0;
      packet_done_q   <= 1'b0;
      error_q         <= 1'b0;
      error_code_q    <= 2'd0;
      busy_q          <= 1'b0;
    end else begin
      header_valid_q  <= 1'b0;
      payload_valid_q <= 1'b0;
      packet_done_q   <= 1'b0;
      error_q         <= 1'b0;

      case (state_q)
        S_IDLE: begin
          idle_cnt_q <= 16'd0;
          if (rx_enable) begin
            data_id_q <= rx_data;
            hdr_cnt_q <= 2'd1;
            busy_q    <= 1'b1;
            state_q   <= S_HEADER;
          end
        end

        S_HEADER, S_PAYLOAD, S_FOOTER: begin
          if (rx_enable) begin
            idle_cnt_q <= 16'd0;
            if (state_q == S_HEADER) begin
              if (hdr_cnt_q == 2'd1) begin
                word_count_q[7:0] <= rx_data;
                hdr_cnt_q         <= 2'd2;
              end else if (hdr_cnt_q == 2'd2) begin
                word_count_q[15:8] <= rx_data;
                hdr_cnt_q          <= 2'd3;
              end else begin
                // ECC byte: the header fields are complete, decide the packet type
                header_valid_q <= 1'b1;
                hdr_cnt_q      <= 2'd0;
                if (data_id_q[5:0] <= 6'h0F) begin
                  packet_done_q <= 1'b1;
                  rx_reset_q    <= 1'b1;
                  flush_cnt_q   <= RESET_LAST;
                  state_q       <= S_FLUSH;
                end else if (word_count_q > MAX_WC) begin
                  error_q      <= 1'b1;
                  error_code_q <= ERR_WC;
                  rx_reset_q   <= 1'b1;
                  flush_cnt_q  <= RESET_LAST;
                  state_q      <= S_FLUSH;
                end else if (word_count_q == 16'd0) begin
                  crc_cnt_q <= 1'b0;
                  state_q   <= S_FOOTER;
                end else begin
                  remain_q <= word_count_q;
                  state_q  <= S_PAYLOAD;
                end
              end
            end else if (state_q == S_PAYLOAD) begin
              payload_data_q  <= rx_data;
              payload_valid_q <= 1'b1;
              remain_q        <= remain_q - 16'd1;
              if (remain_q <= 16'd1) begin
                crc_cnt_q <= 1'b0;
                state_q   <= S_FOOTER;
              end
            end else begin
              if (!crc_cnt_q) begin
                crc_cnt_q <= 1'b1;
              end else begin
                packet_done_q <= 1'b1;
                rx_reset_q    <= 1'b1;
                flush_cnt_q   <= RESET_LAST;
                state_q       <= S_FLUSH;
              end
            end
          end else if (idle_cnt_q == TIMEOUT_LAST) begin
            // Payload already forwarded stays forwarded; only the abort is reported
            idle_cnt_q   <= 16'd0;
            error_q      <= 1'b1;
            error_code_q <= ERR_TIMEOUT;
            rx_reset_q   <= 1'b1;
            flush_cnt_q  <= RESET_LAST;
            state_q      <= S_FLUSH;
          end else begin
            idle_cnt_q <= idle_cnt_q + 16'd1;
          end
        end

        S_FLUSH: begin
          idle_cnt_q <= 16'd0;
          if (flush_cnt_q == 16'd0) begin
            rx_reset_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            flush_cnt_q <= flush_cnt_q - 16'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_reset      = rx_reset_q;
  assign header_valid  = header_valid_q;
  assign data_id       = data_id_q;
  assign word_count    = word_count_q;
  assign payload_data  = payload_data_q;
  assign payload_valid = payload_valid_q;
  assign packet_done   = packet_done_q;
  assign error         = error_q;
  assign error_code    = error_code_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_csi2_packet_sequencer.sv
// Bench for csi2_packet_sequencer: directed packets, expected output events queued at drive time
// with their exact cycle, and a negedge monitor that pops and compares every reported event.

module tb_csi2_packet_sequencer;

  localparam int RC = 2;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_enable = 1'b0;
  logic        rx_reset;
  logic        header_valid;
  logic [7:0]  data_id;
  logic [15:0] word_count;
  logic [7:0]  payload_data;
  logic        payload_valid;
  logic        packet_done;
  logic        error;
  logic [1:0]  error_code;
  logic        busy;

  csi2_packet_sequencer #(
    .MAX_WC      (16'd4096),
    .TIMEOUT     (TO),
    .RESET_CYCLES(RC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_enable    (rx_enable),
    .rx_reset     (rx_reset),
    .header_valid (header_valid),
    .data_id      (data_id),
    .word_count   (word_count),
    .payload_data (payload_data),
    .payload_valid(payload_valid),
    .packet_done  (packet_done),
    .error        (error),
    .error_code   (error_code),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        hv;
    logic        pv;
    logic        pd;
    logic        er;
    logic [7:0]  did;
    logic [15:0] wc;
    logic [7:0]  pdat;
    logic [1:0]  code;
  } ev_t;

  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input int c, input logic hv, input logic pv, input logic pd,
                         input logic er, input logic [7:0] did, input logic [15:0] wc,
                         input logic [7:0] pdat, input logic [1:0] code);
    ev_t e;
    e.cyc = c; e.hv = hv; e.pv = pv; e.pd = pd; e.er = er;
    e.did = did; e.wc = wc; e.pdat = pdat; e.code = code;
    exp_q.push_back(e);
  endtask

  // monitor: every clock with a reported event must match the head of the queue
  always @(negedge clock) begin : monitor
    ev_t e;
    if (reset && (header_valid || payload_valid || packet_done || error)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=hv%0b pv%0b pd%0b er%0b required=none cyc=%0d",
                 header_valid, payload_valid, packet_done, error, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("event_flags", {header_valid, payload_valid, packet_done, error},
            {e.hv, e.pv, e.pd, e.er});
        if (e.hv) begin
          chk("data_id", data_id, e.did);
          chk("word_count", word_count, e.wc);
        end
        if (e.pv) chk("payload_data", payload_data, e.pdat);
        if (e.er) chk("error_code", error_code, e.code);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    rx_enable = 1'b1;
    rx_data   = b;
    t         = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      rx_enable = 1'b0;
      rx_data   = 8'h00;
    end
  endtask

  // rx_reset/busy high for RC clocks while junk bytes are offered, then both low
  task automatic flush_check(input string name);
    for (int i = 0; i < RC; i++) begin
      @(negedge clock);
      chk({name, "_rx_reset_high"}, rx_reset, 1);
      chk({name, "_busy_high"}, busy, 1);
      rx_enable = 1'b1;
      rx_data   = 8'hA5;
    end
    @(negedge clock);
    chk({name, "_rx_reset_low"}, rx_reset, 0);
    chk({name, "_busy_low"}, busy, 0);
    rx_enable = 1'b0;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_outputs"},
        {rx_reset, header_valid, payload_valid, packet_done, error, busy, error_code}, 0);
    chk({name, "_data"}, {data_id, word_count, payload_data}, 0);
  endtask

  task automatic long4_packet(input string name);
    logic [7:0] pl [4];
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send(8'h2A); send(8'h04); send(8'h00); send(8'h77);
    push_ev(t + 1, 1, 0, 0, 0, 8'h2A, 16'h0004, 8'h00, 2'd0);
    for (int i = 0; i < 4; i++) begin
      send(pl[i]);
      push_ev(t + 1, 0, 1, 0, 0, 8'h00, 16'h0000, pl[i], 2'd0);
    end
    send(8'hC0); send(8'hC1);
    push_ev(t + 1, 0, 0, 1, 0, 8'h00, 16'h0000, 8'h00, 2'd0);
    flush_check(name);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk_zero("reset");
    #2 reset = 1'b1;

    // 1: short packet, done together with header
    send(8'h00); send(8'h34); send(8'h12); send(8'h55);
    push_ev(t + 1, 1, 0, 1, 0, 8'h00, 16'h1234, 8'h00, 2'd0);
    flush_check("short");
    chk("short_held", {data_id, word_count}, 24'h00_1234);

    // 2: long packet with four payload bytes
    long4_packet("long4");

    // 3: long packet with zero word count
    send(8'h2A); send(8'h00); send(8'h00); send(8'h33);
    push_ev(t + 1, 1, 0, 0, 0, 8'h2A, 16'h0000, 8'h00, 2'd0);
    send(8'hC0); send(8'hC1);
    push_ev(t + 1, 0, 0, 1, 0, 8'h00, 16'h0000, 8'h00, 2'd0);
    flush_check("wc0");

    // 4a: gaps of 5 clocks, plus one of TIMEOUT-1 which must not abort
    send(8'h2A); idle(5); send(8'h03); idle(5); send(8'h00); idle(5); send(8'h11);
    push_ev(t + 1, 1, 0, 0, 0, 8'h2A, 16'h0003, 8'h00, 2'd0);
    idle(5); send(8'h81);
    push_ev(t + 1, 0, 1, 0, 0, 8'h00, 16'h0000, 8'h81, 2'd0);
    idle(TO - 1); send(8'h82);
    push_ev(t + 1, 0, 1, 0, 0, 8'h00, 16'h0000, 8'h82, 2'd0);
    idle(5); send(8'h83);
    push_ev(t + 1, 0, 1, 0, 0, 8'h00, 16'h0000, 8'h83, 2'd0);
    idle(5); send(8'hC0); idle(5); send(8'hC1);
    push_ev(t + 1, 0, 0, 1, 0, 8'h00, 16'h0000, 8'h00, 2'd0);
    flush_check("gaps");

    // 4b: 16-clock gap after the second payload byte aborts with timeout
    send(8'h2B); send(8'h03); send(8'h00); send(8'h11);
    push_ev(t + 1, 1, 0, 0, 0, 8'h2B, 16'h0003, 8'h00, 2'd0);
    send(8'h44);
    push_ev(t + 1, 0, 1, 0, 0, 8'h00, 16'h0000, 8'h44, 2'd0);
    send(8'h55);
    push_ev(t + 1, 0, 1, 0, 0, 8'h00, 16'h0000, 8'h55, 2'd0);
    push_ev(t + TO + 1, 0, 0, 0, 1, 8'h00, 16'h0000, 8'h00, 2'd1);
    idle(TO);
    flush_check("timeout");

    // 5: word count MAX_WC+1 rejected at the header
    send(8'h2A); send(8'h01); send(8'h10); send(8'h22);
    push_ev(t + 1, 1, 0, 0, 1, 8'h2A, 16'h1001, 8'h00, 2'd2);
    flush_check("wc_big");

    // 5b: word count exactly MAX_WC is accepted, then abandoned by timeout
    send(8'h2A); send(8'h00); send(8'h10); send(8'h22);
    push_ev(t + 1, 1, 0, 0, 0, 8'h2A, 16'h1000, 8'h00, 2'd0);
    push_ev(t + TO + 1, 0, 0, 0, 1, 8'h00, 16'h0000, 8'h00, 2'd1);
    idle(TO);
    flush_check("wc_max");

    // 6: async reset mid-payload, then a clean packet
    send(8'h2A); send(8'h04); send(8'h00); send(8'h77);
    push_ev(t + 1, 1, 0, 0, 0, 8'h2A, 16'h0004, 8'h00, 2'd0);
    send(8'hDE);
    push_ev(t + 1, 0, 1, 0, 0, 8'h00, 16'h0000, 8'hDE, 2'd0);
    send(8'hAD);
    push_ev(t + 1, 0, 1, 0, 0, 8'h00, 16'h0000, 8'hAD, 2'd0);
    @(negedge clock);
    rx_enable = 1'b0;
    #2 reset = 1'b0;
    #1 chk_zero("midreset");
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    long4_packet("after_reset");

    idle(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
